// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered one-cycle match pulse and keeps a saturating match count.
module seq_detect_param #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(8'h0D),
  parameter int unsigned         RST_LEN     = 4,
  parameter bit                  RST_OVERLAP = 1'b1
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           d_in,
  input  logic                           d_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           found,
  output logic [CNT_W-1:0]               match_count,
  output logic [$clog2(MAX_LEN+1)-1:0]   cur_len
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] RST_LEN_C =
      (RST_LEN == 0)       ? LEN_W'(1) :
      (RST_LEN > MAX_LEN)  ? LEN_W'(MAX_LEN) : LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W:0]     fill_p1;
  logic               match_c;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(1);
    else if (32'(l) > MAX_LEN)
      return LEN_W'(MAX_LEN);
    else
      return l;
  endfunction

  // Match is judged on the post-shift history, restricted to the low len bits
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], d_in};
    fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    fill_p1  = {1'b0, fill} + (LEN_W+1)'(1);
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    match_c = d_valid && !cfg_load && (fill_p1 >= {1'b0, len})
              && (((hist_nxt ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pattern <= RST_PATTERN;
      len     <= RST_LEN_C;
      overlap <= RST_OVERLAP;
      hist    <= '0;
      fill    <= '0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= clamp_len(cfg_len);
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
    end else if (d_valid) begin
      hist <= hist_nxt;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits
      fill <= (match_c && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      found       <= 1'b0;
      match_count <= '0;
    end else begin
      found <= match_c;
      if (cnt_clr)
        match_count <= '0;
      else if (match_c && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
    end
  end

  assign cur_len = len;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a default instance plus a 2-bit-counter instance on shared stimulus.
module tb_seq_detect_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clock = 1'b0;
  logic               rst_n = 1'b0;
  logic               d_in = 1'b0;
  logic               d_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic               found, found_s;
  logic [7:0]         match_count;
  logic [1:0]         match_count_s;
  logic [LEN_W-1:0]   cur_len, cur_len_s;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  seq_detect_param dut (
    .clock(clock), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .found(found), .match_count(match_count), .cur_len(cur_len)
  );

  seq_detect_param #(.CNT_W(2)) dut_s (
    .clock(clock), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .found(found_s), .match_count(match_count_s), .cur_len(cur_len_s)
  );

  always #5 clock = ~clock;

  // One clock with the given serial bit; strobes drop afterwards
  task automatic step(input logic d, input logic v);
    d_in = d;
    d_valid = v;
    @(posedge clock);
    #1;
    d_valid  = 1'b0;
    cnt_clr  = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    step(1'b1, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    step(1'b1, 1'b1);
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL reset_found: got %b want 0", found); end
    n_checks++;
    if (match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_checks++;
    if (cur_len !== 4'd4) begin n_fail++; $display("FAIL reset_len: got %0d want 4", cur_len); end
    rst_n = 1'b1;
  endtask

  task automatic test_overlap;
    logic [6:0] bits;
    logic [6:0] exps;
    logic       e;
    bits = 7'b1101101;
    exps = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      exp_q.push_back(exps[i]);
      step(bits[i], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (found !== e) begin n_fail++; $display("FAIL overlap_found bit %0d: got %b want %b", 7 - i, found, e); end
    end
    n_checks++;
    if (match_count !== 8'd2) begin n_fail++; $display("FAIL overlap_count: got %0d want 2", match_count); end
  endtask

  task automatic test_non_overlap;
    logic [6:0] bits;
    logic [6:0] exps;
    logic       e;
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    load_cfg(8'h0D, 4'd4, 1'b0);
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL load_found: got %b want 0", found); end
    bits = 7'b1101101;
    exps = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      exp_q.push_back(exps[i]);
      step(bits[i], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (found !== e) begin n_fail++; $display("FAIL nonov_found bit %0d: got %b want %b", 7 - i, found, e); end
    end
    n_checks++;
    if (match_count !== 8'd1) begin n_fail++; $display("FAIL nonov_count: got %0d want 1", match_count); end
  endtask

  task automatic test_idle;
    logic [8:0] bits;
    logic [8:0] vals;
    logic [8:0] exps;
    logic       e;
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    bits = 9'b111101111;
    vals = 9'b111110001;
    exps = 9'b000000001;
    for (int i = 8; i >= 0; i--) begin
      exp_q.push_back(exps[i]);
      step(bits[i], vals[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (found !== e) begin n_fail++; $display("FAIL idle_found cycle %0d: got %b want %b", 9 - i, found, e); end
    end
    n_checks++;
    if (match_count !== 8'd1) begin n_fail++; $display("FAIL idle_count: got %0d want 1", match_count); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_s;
    logic [7:0] exp_c;
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    // Upper pattern bits are junk and must not take part in the compare
    load_cfg(8'hA5, 4'd1, 1'b1);
    exp_s = 2'd0;
    exp_c = 8'd0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(1'b1);
      if (exp_s != 2'd3) exp_s = exp_s + 2'd1;
      exp_c = exp_c + 8'd1;
      step(1'b1, 1'b1);
      n_checks++;
      if (found !== exp_q.pop_front()) begin n_fail++; $display("FAIL sat_found %0d: got %b want 1", i, found); end
      n_checks++;
      if (match_count_s !== exp_s) begin n_fail++; $display("FAIL sat_count_s %0d: got %0d want %0d", i, match_count_s, exp_s); end
      n_checks++;
      if (match_count !== exp_c) begin n_fail++; $display("FAIL sat_count %0d: got %0d want %0d", i, match_count, exp_c); end
    end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    n_checks++;
    if (found_s !== 1'b1) begin n_fail++; $display("FAIL clr_found: got %b want 1", found_s); end
    n_checks++;
    if (match_count_s !== 2'd0) begin n_fail++; $display("FAIL clr_count_s: got %0d want 0", match_count_s); end
    n_checks++;
    if (match_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", match_count); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] bits;
    logic [7:0] exps;
    logic       e;
    load_cfg(8'h0D, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step((i == 2) ? 1'b0 : 1'b1, 1'b1);
    end
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL mid_rst_found: got %b want 0", found); end
    bits = 8'b00011101;
    exps = 8'b00000001;
    for (int i = 4; i >= 0; i--) begin
      exp_q.push_back(exps[i]);
      step(bits[i], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (found !== e) begin n_fail++; $display("FAIL mid_found bit %0d: got %b want %b", 5 - i, found, e); end
    end
    load_cfg(8'h0D, 4'd0, 1'b1);
    n_checks++;
    if (cur_len !== 4'd1) begin n_fail++; $display("FAIL clamp_low: got %0d want 1", cur_len); end
    load_cfg(8'h0D, 4'(MAX_LEN + 3), 1'b1);
    n_checks++;
    if (cur_len !== 4'(MAX_LEN)) begin n_fail++; $display("FAIL clamp_high: got %0d want %0d", cur_len, MAX_LEN); end
    n_checks++;
    if (cur_len_s !== 4'(MAX_LEN)) begin n_fail++; $display("FAIL clamp_high_s: got %0d want %0d", cur_len_s, MAX_LEN); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_idle();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
